// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues imem reads, predecodes JAL for early
// redirect, and buffers fetched instructions in a small queue for decode.
module fetch_queue #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned JAL_PREDECODE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_ren,
    output logic [31:0] imem_raddr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr,
    output logic        dec_jal
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        jal;
    } entry_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic          inflight_q;
    logic [31:0]   req_pc_q;
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    entry_t        store [DEPTH];

    logic          redir;
    logic          issue_ok;
    logic          issue;
    logic          resp_jal;
    logic [31:0]   jal_imm;
    logic [31:0]   pc_jal;
    logic          push;
    logic          pop;
    entry_t        head;

    // Response decode and JAL target computation
    always_comb begin
        redir    = redirect_valid && !rst;
        resp_jal = (JAL_PREDECODE != 0) && inflight_q
                   && (imem_rdata[6:0] == 7'b1101111) && !redirect_valid;
        jal_imm  = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                    imem_rdata[20], imem_rdata[30:21], 1'b0};
        pc_jal   = req_pc_q + jal_imm;
    end

    // Issue decision; the reservation counts only registered occupancy
    always_comb begin
        issue_ok = (state == RUN) && ((count + CW'(inflight_q)) < CW'(DEPTH));
        issue    = !rst && (redirect_valid || issue_ok);
        imem_ren = issue;
        if (redir) begin
            imem_raddr = redirect_pc;
        end else if (resp_jal) begin
            imem_raddr = pc_jal;
        end else begin
            imem_raddr = fetch_pc;
        end
    end

    always_comb begin
        push      = inflight_q && !redir;
        dec_valid = (count != '0);
        pop       = dec_valid && dec_ready && !redir;
        head      = store[rd_ptr];
        dec_pc    = dec_valid ? head.pc    : 32'h0;
        dec_instr = dec_valid ? head.instr : 32'h0;
        dec_jal   = dec_valid && head.jal;
    end

    // Control state: FSM, fetch PC, in-flight tracking and queue occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            inflight_q <= 1'b0;
            req_pc_q   <= 32'h0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (state == IDLE && start) begin
                state <= RUN;
            end

            inflight_q <= issue;
            if (issue) begin
                req_pc_q <= imem_raddr;
                fetch_pc <= imem_raddr + 32'd4;
            end else if (resp_jal) begin
                // Reservation full: park the JAL target so it is fetched later
                fetch_pc <= pc_jal;
            end

            if (redir) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    // Queue storage holds data only; validity lives in count/pointers
    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= '{pc: req_pc_q, instr: imem_rdata, jal: resp_jal};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: per-cycle vector tables plus a decode-side scoreboard.
module tb_fetch_queue;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] JAL16 = 32'h0100_006F;
    localparam logic [31:0] NONE  = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        start;
    logic        imem_ren;
    logic [31:0] imem_raddr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_jal;

    fetch_queue #(
        .RESET_PC(32'h0000_0000),
        .DEPTH(4),
        .JAL_PREDECODE(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .imem_ren(imem_ren),
        .imem_raddr(imem_raddr),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .dec_valid(dec_valid),
        .dec_ready(dec_ready),
        .dec_pc(dec_pc),
        .dec_instr(dec_instr),
        .dec_jal(dec_jal)
    );

    typedef struct {
        logic        st;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ren;
        logic [31:0] raddr;
        logic        dv;
        logic [31:0] dpc;
        logic        djal;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        jal;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    exp_t        e;
    logic [31:0] mem [256];
    int          tests = 0;
    int          fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: one-cycle read latency
    always @(posedge clk) begin
        if (imem_ren) imem_rdata <= mem[imem_raddr[9:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted decode entry must match the next expected one
    always @(negedge clk) begin
        if (!rst && dec_valid && dec_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got pc %h expected no entry", dec_pc);
            end else begin
                e = sb.pop_front();
                check("sb_pc", dec_pc, e.pc);
                check("sb_instr", dec_instr, e.instr);
                check("sb_jal", 32'(dec_jal), 32'(e.jal));
            end
        end
    end

    task automatic load(input logic [31:0] jal_addr);
        for (int i = 0; i < 256; i++) mem[i] = NOP;
        if (jal_addr != NONE) mem[jal_addr[9:2]] = JAL16;
    endtask

    task automatic v(input logic st, input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic ren, input logic [31:0] raddr, input logic dv,
                     input logic [31:0] dpc, input logic djal);
        vecs.push_back('{st, rdy, rv, rpc, ren, raddr, dv, dpc, djal});
    endtask

    task automatic expect_pop(input logic [31:0] pc, input logic [31:0] instr, input logic jal);
        sb.push_back('{pc, instr, jal});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ren"}, 32'(imem_ren), 32'h0);
        check({tag, "_raddr"}, imem_raddr, 32'h0);
        check({tag, "_dv"}, 32'(dec_valid), 32'h0);
        check({tag, "_dpc"}, dec_pc, 32'h0);
        check({tag, "_dinstr"}, dec_instr, 32'h0);
        check({tag, "_djal"}, 32'(dec_jal), 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; dec_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic apply_vectors(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            start          = vecs[i].st;
            dec_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            #1;
            check($sformatf("%s_c%0d_ren", tag, i), 32'(imem_ren), 32'(vecs[i].ren));
            check($sformatf("%s_c%0d_raddr", tag, i), imem_raddr, vecs[i].raddr);
            check($sformatf("%s_c%0d_dv", tag, i), 32'(dec_valid), 32'(vecs[i].dv));
            check($sformatf("%s_c%0d_dpc", tag, i), dec_pc, vecs[i].dpc);
            check($sformatf("%s_c%0d_djal", tag, i), 32'(dec_jal), 32'(vecs[i].djal));
        end
        @(posedge clk); #1;
        start = 1'b0; redirect_valid = 1'b0; dec_ready = 1'b0;
        check({tag, "_sb_drain"}, 32'(sb.size()), 32'h0);
        vecs.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; dec_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0055;
        load(NONE);
        #12;
        check_reset_outputs("por");
        redirect_valid = 1'b0;

        // Straight-line NOP fetch
        do_reset();
        load(NONE);
        v(1,1,0,0, 0,32'h00, 0,32'h00,0);
        v(0,1,0,0, 1,32'h00, 0,32'h00,0);
        v(0,1,0,0, 1,32'h04, 0,32'h00,0);
        v(0,1,0,0, 1,32'h08, 1,32'h00,0);
        v(0,1,0,0, 1,32'h0C, 1,32'h04,0);
        v(0,1,0,0, 1,32'h10, 1,32'h08,0);
        v(0,1,0,0, 1,32'h14, 1,32'h0C,0);
        v(0,1,0,0, 1,32'h18, 1,32'h10,0);
        for (int a = 0; a <= 32'h10; a += 4) expect_pop(32'(a), NOP, 1'b0);
        apply_vectors("line");

        // JAL predecode at 0x8 redirects to 0x18 without a bubble
        do_reset();
        load(32'h08);
        v(1,1,0,0, 0,32'h00, 0,32'h00,0);
        v(0,1,0,0, 1,32'h00, 0,32'h00,0);
        v(0,1,0,0, 1,32'h04, 0,32'h00,0);
        v(0,1,0,0, 1,32'h08, 1,32'h00,0);
        v(0,1,0,0, 1,32'h18, 1,32'h04,0);
        v(0,1,0,0, 1,32'h1C, 1,32'h08,1);
        v(0,1,0,0, 1,32'h20, 1,32'h18,0);
        v(0,1,0,0, 1,32'h24, 1,32'h1C,0);
        expect_pop(32'h00, NOP, 1'b0);
        expect_pop(32'h04, NOP, 1'b0);
        expect_pop(32'h08, JAL16, 1'b1);
        expect_pop(32'h18, NOP, 1'b0);
        expect_pop(32'h1C, NOP, 1'b0);
        apply_vectors("jal");

        // Backpressure: four requests fill the queue, then fetch resumes at 0x10
        do_reset();
        load(NONE);
        v(1,0,0,0, 0,32'h00, 0,32'h00,0);
        v(0,0,0,0, 1,32'h00, 0,32'h00,0);
        v(0,0,0,0, 1,32'h04, 0,32'h00,0);
        v(0,0,0,0, 1,32'h08, 1,32'h00,0);
        v(0,0,0,0, 1,32'h0C, 1,32'h00,0);
        v(0,0,0,0, 0,32'h10, 1,32'h00,0);
        v(0,0,0,0, 0,32'h10, 1,32'h00,0);
        v(0,1,0,0, 0,32'h10, 1,32'h00,0);
        v(0,1,0,0, 1,32'h10, 1,32'h04,0);
        v(0,1,0,0, 1,32'h14, 1,32'h08,0);
        v(0,1,0,0, 1,32'h18, 1,32'h0C,0);
        v(0,1,0,0, 1,32'h1C, 1,32'h10,0);
        v(0,1,0,0, 1,32'h20, 1,32'h14,0);
        for (int a = 0; a <= 32'h14; a += 4) expect_pop(32'(a), NOP, 1'b0);
        apply_vectors("bp");

        // JAL at 0xC arrives with the reservation full; target 0x1C fetched later
        do_reset();
        load(32'h0C);
        v(1,0,0,0, 0,32'h00, 0,32'h00,0);
        v(0,0,0,0, 1,32'h00, 0,32'h00,0);
        v(0,0,0,0, 1,32'h04, 0,32'h00,0);
        v(0,0,0,0, 1,32'h08, 1,32'h00,0);
        v(0,0,0,0, 1,32'h0C, 1,32'h00,0);
        v(0,0,0,0, 0,32'h1C, 1,32'h00,0);
        v(0,0,0,0, 0,32'h1C, 1,32'h00,0);
        v(0,1,0,0, 0,32'h1C, 1,32'h00,0);
        v(0,1,0,0, 1,32'h1C, 1,32'h04,0);
        v(0,1,0,0, 1,32'h20, 1,32'h08,0);
        v(0,1,0,0, 1,32'h24, 1,32'h0C,1);
        v(0,1,0,0, 1,32'h28, 1,32'h1C,0);
        expect_pop(32'h00, NOP, 1'b0);
        expect_pop(32'h04, NOP, 1'b0);
        expect_pop(32'h08, NOP, 1'b0);
        expect_pop(32'h0C, JAL16, 1'b1);
        expect_pop(32'h1C, NOP, 1'b0);
        apply_vectors("jalfull");

        // Redirect colliding with response and pop, then back-to-back redirects
        do_reset();
        load(NONE);
        v(1,1,0,0,          0,32'h000, 0,32'h000,0);
        v(0,1,0,0,          1,32'h000, 0,32'h000,0);
        v(0,1,0,0,          1,32'h004, 0,32'h000,0);
        v(0,1,0,0,          1,32'h008, 1,32'h000,0);
        v(0,1,1,32'h100,    1,32'h100, 1,32'h004,0);
        v(0,1,0,0,          1,32'h104, 0,32'h000,0);
        v(0,1,0,0,          1,32'h108, 1,32'h100,0);
        v(0,1,0,0,          1,32'h10C, 1,32'h104,0);
        v(0,1,1,32'h200,    1,32'h200, 1,32'h108,0);
        v(0,1,1,32'h300,    1,32'h300, 0,32'h000,0);
        v(0,1,0,0,          1,32'h304, 0,32'h000,0);
        v(0,1,0,0,          1,32'h308, 1,32'h300,0);
        expect_pop(32'h000, NOP, 1'b0);
        expect_pop(32'h100, NOP, 1'b0);
        expect_pop(32'h104, NOP, 1'b0);
        expect_pop(32'h300, NOP, 1'b0);
        apply_vectors("redir");

        // Reset asserted mid-run with three queued entries
        do_reset();
        load(NONE);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_dv_before", 32'(dec_valid), 32'h1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid");
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        @(posedge clk); #1;
        check("mid_idle_ren", 32'(imem_ren), 32'h0);
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        #1;
        check("mid_first_ren", 32'(imem_ren), 32'h1);
        check("mid_first_raddr", imem_raddr, 32'h0);
        @(posedge clk); #2;
        check("mid_second_raddr", imem_raddr, 32'h4);
        check("mid_second_dv", 32'(dec_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
